// File: rtl/hazard_ctrl.sv
// Pipeline hazard/sequencing controller: load-use stalls, jump flushes, RET/RTI fetch hold
// and a three-step interrupt entry sequence (push PC, push flags, load vector).
module hazard_ctrl #(
  parameter int RET_BUBBLES = 2,
  parameter int ADDR_W      = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] id_src1,
  input  logic [ADDR_W-1:0] id_src2,
  input  logic              id_use1,
  input  logic              id_use2,
  input  logic              ex_mr,
  input  logic              ex_wb,
  input  logic [ADDR_W-1:0] ex_wb_addr,
  input  logic              ex_jmp,
  input  logic              ex_jwsp,
  input  logic              int_req,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic              int_push_pc,
  output logic              int_push_flags,
  output logic              pc_sel_vec,
  output logic              int_ack
);

  typedef enum logic [2:0] {
    RUN       = 3'd0,
    RET_WAIT  = 3'd1,
    INT_PC    = 3'd2,
    INT_FLAGS = 3'd3,
    INT_VEC   = 3'd4
  } state_t;

  localparam logic [2:0] RET_INIT = 3'(RET_BUBBLES - 1);

  state_t     state_reg, state_next;
  logic [2:0] ret_cnt_reg, ret_cnt_next;
  logic       int_pend_reg, int_pend_next;
  logic       load_use;

  assign load_use = ex_mr & ex_wb &
                    ((id_use1 & (id_src1 == ex_wb_addr)) |
                     (id_use2 & (id_src2 == ex_wb_addr)));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= RUN;
      ret_cnt_reg  <= 3'd0;
      int_pend_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      ret_cnt_reg  <= ret_cnt_next;
      int_pend_reg <= int_pend_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    ret_cnt_next   = ret_cnt_reg;
    int_pend_next  = int_pend_reg;
    pc_write       = 1'b0;
    ifid_write     = 1'b0;
    ifid_flush     = 1'b0;
    idex_flush     = 1'b0;
    int_push_pc    = 1'b0;
    int_push_flags = 1'b0;
    pc_sel_vec     = 1'b0;
    int_ack        = 1'b0;

    case (state_reg)
      RUN: begin
        int_pend_next = int_pend_reg | int_req;
        if (ex_jwsp) begin
          ifid_flush   = 1'b1;
          idex_flush   = 1'b1;
          ret_cnt_next = RET_INIT;
          state_next   = RET_WAIT;
        end else if (ex_jmp) begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
          pc_write   = 1'b1;
        end else if (load_use) begin
          idex_flush = 1'b1;
        end else if (int_pend_reg | int_req) begin
          int_ack       = 1'b1;
          ifid_flush    = 1'b1;
          int_pend_next = 1'b0;
          state_next    = INT_PC;
        end else begin
          pc_write   = 1'b1;
          ifid_write = 1'b1;
        end
      end
      RET_WAIT: begin
        // Interrupts arriving here are remembered and taken once back in RUN.
        int_pend_next = int_pend_reg | int_req;
        ifid_flush    = 1'b1;
        if (ret_cnt_reg == 3'd0) begin
          pc_write   = 1'b1;
          state_next = RUN;
        end else begin
          ret_cnt_next = ret_cnt_reg - 3'd1;
        end
      end
      INT_PC: begin
        int_push_pc = 1'b1;
        ifid_flush  = 1'b1;
        state_next  = INT_FLAGS;
      end
      INT_FLAGS: begin
        int_push_flags = 1'b1;
        ifid_flush     = 1'b1;
        state_next     = INT_VEC;
      end
      INT_VEC: begin
        pc_sel_vec = 1'b1;
        pc_write   = 1'b1;
        ifid_flush = 1'b1;
        state_next = RUN;
      end
      default: state_next = RUN;
    endcase

    // Outputs must show the idle-run values for as long as reset is held, whatever the inputs.
    if (!reset) begin
      pc_write       = 1'b1;
      ifid_write     = 1'b1;
      ifid_flush     = 1'b0;
      idex_flush     = 1'b0;
      int_push_pc    = 1'b0;
      int_push_flags = 1'b0;
      pc_sel_vec     = 1'b0;
      int_ack        = 1'b0;
    end
  end

endmodule
